lc3_pipe_ctrl: RTL

LC3_PIPE_CTRL -- requirements
Module: lc3_pipe_ctrl

---
 rtl/lc3_pipe_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/lc3_pipe_ctrl.sv
// lc3_pipe_ctrl: pipeline enable, memory-stall and control-flow bubble
// sequencing for a five-stage LC-3 pipeline.
// Optional macro: LC3_PIPE_CTRL_BYPASS_EN enables ALU forwarding outputs;
// when undefined both bypass outputs are tied to 0.
`timescale 1ns/1ps

module lc3_pipe_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_data,
  input  logic        complete_instr,
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  psr,
  output logic        enable_updatePC,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        br_taken,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic [1:0]  mem_state
);

  typedef enum logic [1:0] {
    MEM_READ     = 2'd0,
    MEM_INDIRECT = 2'd1,
    MEM_WRITE    = 2'd2,
    MEM_RUN      = 2'd3
  } mem_state_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;

  mem_state_t state_q;
  logic [2:0] fill_q;
  logic [1:0] bubble_q;
  logic [3:0] op_d;
  logic [3:0] op_x;
  logic       run;
  logic       front_ok;
  logic       unused_bits;

  assign op_d        = IR[15:12];
  assign op_x        = IR_Exec[15:12];
  assign run         = (state_q == MEM_RUN);
  assign mem_state   = state_q;
  assign unused_bits = ^{IR[11:0], IR_Exec[8:0]};

  // Stage enables: fill level gated by memory stall, fetch validity and bubble.
  always_comb begin
    front_ok         = run && complete_instr && (bubble_q == 2'd0);
    enable_updatePC  = front_ok && (fill_q >= 3'd1);
    enable_fetch     = front_ok && (fill_q >= 3'd1);
    enable_decode    = front_ok && (fill_q >= 3'd2);
    enable_execute   = run && (fill_q >= 3'd3);
    // A completing load retires its result in the cycle it leaves READ.
    enable_writeback = (run && (fill_q >= 3'd4)) ||
                       ((state_q == MEM_READ) && complete_data);
  end

  // Branch resolution in execute.
  always_comb begin
    br_taken = 1'b0;
    if (enable_execute) begin
      if (op_x == OP_JMP)
        br_taken = 1'b1;
      else if ((op_x == OP_BR) && ((IR_Exec[11:9] & psr) != 3'b000))
        br_taken = 1'b1;
    end
  end

`ifdef LC3_PIPE_CTRL_BYPASS_EN
  logic exec_alu;
  logic dec_sr1_user;
  logic dec_sr2_user;

  // Forward the execute-stage ALU result when decode reads the same register.
  always_comb begin
    exec_alu     = (op_x == OP_ADD) || (op_x == OP_AND) || (op_x == OP_NOT);
    dec_sr1_user = (op_d == OP_ADD) || (op_d == OP_AND) || (op_d == OP_NOT) ||
                   (op_d == OP_LDR) || (op_d == OP_STR);
    dec_sr2_user = ((op_d == OP_ADD) || (op_d == OP_AND)) && !IR[5];
    bypass_alu_1 = enable_execute && exec_alu && dec_sr1_user &&
                   (IR_Exec[11:9] == IR[8:6]);
    bypass_alu_2 = enable_execute && exec_alu && dec_sr2_user &&
                   (IR_Exec[11:9] == IR[2:0]);
  end
`else
  assign bypass_alu_1 = 1'b0;
  assign bypass_alu_2 = 1'b0;
`endif

  // Pipeline fill counter, saturating at 4 after reset release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      fill_q <= 3'd0;
    else if (fill_q != 3'd4)
      fill_q <= fill_q + 3'd1;
  end

  // Control-flow bubble: load on BR/JMP in decode, count down only while running.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      bubble_q <= 2'd0;
    else if (enable_decode && ((op_d == OP_BR) || (op_d == OP_JMP)))
      bubble_q <= 2'd3;
    else if ((bubble_q != 2'd0) && run)
      bubble_q <= bubble_q - 2'd1;
  end

  // Memory access FSM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= MEM_RUN;
    end else begin
      case (state_q)
        MEM_RUN: begin
          if (enable_execute) begin
            case (op_x)
              OP_LD, OP_LDR:  state_q <= MEM_READ;
              OP_ST, OP_STR:  state_q <= MEM_WRITE;
              OP_LDI, OP_STI: state_q <= MEM_INDIRECT;
              default:        state_q <= MEM_RUN;
            endcase
          end
        end
        MEM_INDIRECT: begin
          if (complete_data)
            state_q <= (op_x == OP_LDI) ? MEM_READ : MEM_WRITE;
        end
        MEM_READ, MEM_WRITE: begin
          if (complete_data)
            state_q <= MEM_RUN;
        end
        default: state_q <= MEM_RUN;
      endcase
    end
  end

endmodule
